// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand server.
// Holds the bus-owner state encoding, the host select encoding and the
// default sizing parameters.
package mac_pkg;

    localparam int PL_DEF = 4;   // multiplier lanes (A regfile depth)
    localparam int DW_DEF = 64;  // data word width
    localparam int AW_DEF = 13;  // word address width

    // Who currently owns the operand RAMs.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_MAC  = 2'd2
    } own_st_e;

    // Host target select.
    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_X = 2'd2;
    localparam logic [1:0] SEL_Y = 2'd3;

endpackage

// File: rtl/mac_opnd_rdport.sv
// One MAC-side operand read path: RAM strobe/address generation, capture of
// the 1-cycle-latency RAM data, and hold of the last returned word.
// With MAC_OPND_SRV_BNDCHK_EN defined, reads at ptr >= len are blocked,
// return zero and raise o_err for one cycle.
module mac_opnd_rdport
    import mac_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_en,     // MAC owns the RAMs
    input  logic          i_rd,
    input  logic [AW-1:0] i_ptr,
    input  logic [AW-1:0] i_len,
    input  logic [AW-1:0] i_base,
    input  logic [DW-1:0] i_rdata,
    output logic          o_cs,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_dat,
    output logic          o_err
);

    logic          w_strobe;
    logic          w_oob;
    logic          r_pend;
    logic          r_oob;
    logic [DW-1:0] r_hold;

    assign w_strobe = i_en & i_rd;

`ifdef MAC_OPND_SRV_BNDCHK_EN
    assign w_oob = (i_ptr >= i_len);
`else
    logic w_unused_len;
    assign w_oob        = 1'b0;
    assign w_unused_len = ^i_len;
`endif

    // Address wraps naturally at 2^AW.
    assign o_cs   = w_strobe & ~w_oob;
    assign o_addr = w_strobe ? (i_base + i_ptr) : '0;
    assign o_err  = w_strobe & w_oob;

    // Data is live from the RAM in the cycle after the strobe, held otherwise.
    assign o_dat = r_pend ? (r_oob ? '0 : i_rdata) : r_hold;

    // Track the outstanding read and keep the last delivered word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= 1'b0;
            r_oob  <= 1'b0;
            r_hold <= '0;
        end else begin
            r_pend <= w_strobe;
            r_oob  <= w_oob;
            r_hold <= o_dat;
        end
    end

endmodule

// File: rtl/mac_opnd_srv.sv
// MAC operand server: arbitrates the B/X/Y operand RAMs and the A register
// file between a host port and a running MAC job.
// Optional: MAC_OPND_SRV_BNDCHK_EN enables B/X read bound checking and the
// sticky err flag; without it err is tied low.
module mac_opnd_srv
    import mac_pkg::*;
#(
    parameter int PL = PL_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mac_start,
    input  logic          mac_done,
    // MAC side
    input  logic [AW-1:0] daptr,
    input  logic [AW-1:0] dbptr,
    input  logic [AW-1:0] dxptr,
    input  logic [AW-1:0] dyptr,
    input  logic          dard,
    input  logic          dbrd,
    input  logic          dxrd,
    input  logic          dywr,
    output logic [DW-1:0] dardat,
    output logic [DW-1:0] dbrdat,
    output logic [DW-1:0] dxrdat,
    input  logic [DW-1:0] dywdat,
    input  logic [AW-1:0] dblen,
    input  logic [AW-1:0] dxlen,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] base_x,
    input  logic [AW-1:0] base_y,
    // B RAM
    output logic          rb_cs,
    output logic          rb_we,
    output logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_wdata,
    input  logic [DW-1:0] rb_rdata,
    // X RAM
    output logic          rx_cs,
    output logic          rx_we,
    output logic [AW-1:0] rx_addr,
    output logic [DW-1:0] rx_wdata,
    input  logic [DW-1:0] rx_rdata,
    // Y RAM
    output logic          ry_cs,
    output logic          ry_we,
    output logic [AW-1:0] ry_addr,
    output logic [DW-1:0] ry_wdata,
    input  logic [DW-1:0] ry_rdata,
    // Host
    input  logic          h_req,
    input  logic          h_we,
    input  logic [1:0]    h_sel,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_ack,
    output logic [DW-1:0] h_rdata,
    output logic          err
);

    own_st_e               r_st;
    logic                  r_h_we;
    logic [1:0]            r_h_sel;
    logic [AW-1:0]         r_h_addr;
    logic [DW-1:0]         r_h_wdata;
    logic                  r_h_ack;
    logic [AW-1:0]         r_base_b, r_base_x, r_base_y;
    logic [PL-1:0][DW-1:0] r_areg;
    logic [DW-1:0]         r_adat;

    logic                  w_mac, w_host, w_start, w_h_acc;
    logic                  w_hb, w_hx, w_hy, w_my;
    logic [DW-1:0]         w_adat, w_h_adat;
    logic                  w_b_cs, w_x_cs, w_b_err, w_x_err;
    logic [AW-1:0]         w_b_addr, w_x_addr;

    assign w_mac   = (r_st == OWN_MAC);
    assign w_host  = (r_st == OWN_HOST);
    assign w_start = (r_st == OWN_IDLE) && mac_start;
    // A read ack cycle is already back in IDLE; hold off a new grant there so
    // a host still holding h_req is not served twice.
    assign w_h_acc = (r_st == OWN_IDLE) && !mac_start && h_req && !r_h_ack;

    // Owner FSM; mac_start beats a simultaneous h_req, host request is latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st      <= OWN_IDLE;
            r_h_we    <= 1'b0;
            r_h_sel   <= SEL_A;
            r_h_addr  <= '0;
            r_h_wdata <= '0;
        end else begin
            case (r_st)
                OWN_IDLE: begin
                    if (mac_start) begin
                        r_st <= OWN_MAC;
                    end else if (w_h_acc) begin
                        r_st      <= OWN_HOST;
                        r_h_we    <= h_we;
                        r_h_sel   <= h_sel;
                        r_h_addr  <= h_addr;
                        r_h_wdata <= h_wdata;
                    end
                end
                OWN_HOST: r_st <= OWN_IDLE;
                OWN_MAC:  if (mac_done) r_st <= OWN_IDLE;
                default:  r_st <= OWN_IDLE;
            endcase
        end
    end

    // Ack: writes in the HOST cycle, reads in the cycle after it (RAM latency).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_h_ack <= 1'b0;
        else       r_h_ack <= (w_h_acc && h_we) || (w_host && !r_h_we);
    end

    // Job base offsets are frozen at job start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base_b <= '0;
            r_base_x <= '0;
            r_base_y <= '0;
        end else if (w_start) begin
            r_base_b <= base_b;
            r_base_x <= base_x;
            r_base_y <= base_y;
        end
    end

    // A regfile lookups; indices past PL read as zero.
    always_comb begin
        w_adat   = '0;
        w_h_adat = '0;
        for (int i = 0; i < PL; i++) begin
            if (daptr == AW'(i))    w_adat   = r_areg[i];
            if (r_h_addr == AW'(i)) w_h_adat = r_areg[i];
        end
    end

    // A regfile is written only by the host.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_areg <= '0;
        end else if (w_host && r_h_we && (r_h_sel == SEL_A)) begin
            for (int i = 0; i < PL; i++)
                if (r_h_addr == AW'(i)) r_areg[i] <= r_h_wdata;
        end
    end

    // A read data: registered on dard, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             r_adat <= '0;
        else if (w_mac && dard) r_adat <= w_adat;
    end
    assign dardat = r_adat;

    mac_opnd_rdport #(.DW(DW), .AW(AW)) u_rd_b (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_mac),
        .i_rd   (dbrd),
        .i_ptr  (dbptr),
        .i_len  (dblen),
        .i_base (r_base_b),
        .i_rdata(rb_rdata),
        .o_cs   (w_b_cs),
        .o_addr (w_b_addr),
        .o_dat  (dbrdat),
        .o_err  (w_b_err)
    );

    mac_opnd_rdport #(.DW(DW), .AW(AW)) u_rd_x (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_mac),
        .i_rd   (dxrd),
        .i_ptr  (dxptr),
        .i_len  (dxlen),
        .i_base (r_base_x),
        .i_rdata(rx_rdata),
        .o_cs   (w_x_cs),
        .o_addr (w_x_addr),
        .o_dat  (dxrdat),
        .o_err  (w_x_err)
    );

    // RAM port muxes: host uses raw addresses, MAC uses the rdport / Y path.
    assign w_hb = w_host && (r_h_sel == SEL_B);
    assign w_hx = w_host && (r_h_sel == SEL_X);
    assign w_hy = w_host && (r_h_sel == SEL_Y);
    assign w_my = w_mac && dywr;

    assign rb_cs    = w_b_cs | w_hb;
    assign rb_we    = w_hb & r_h_we;
    assign rb_addr  = w_hb ? r_h_addr : w_b_addr;
    assign rb_wdata = (w_hb && r_h_we) ? r_h_wdata : '0;

    assign rx_cs    = w_x_cs | w_hx;
    assign rx_we    = w_hx & r_h_we;
    assign rx_addr  = w_hx ? r_h_addr : w_x_addr;
    assign rx_wdata = (w_hx && r_h_we) ? r_h_wdata : '0;

    assign ry_cs    = w_my | w_hy;
    assign ry_we    = w_my | (w_hy & r_h_we);
    assign ry_addr  = w_hy ? r_h_addr : (w_my ? (r_base_y + dyptr) : '0);
    assign ry_wdata = w_hy ? (r_h_we ? r_h_wdata : '0) : (w_my ? dywdat : '0);

    // Host read data is presented only in the ack cycle.
    always_comb begin
        h_rdata = '0;
        if (r_h_ack && !r_h_we) begin
            case (r_h_sel)
                SEL_A:   h_rdata = w_h_adat;
                SEL_B:   h_rdata = rb_rdata;
                SEL_X:   h_rdata = rx_rdata;
                default: h_rdata = ry_rdata;
            endcase
        end
    end
    assign h_ack = r_h_ack;

`ifdef MAC_OPND_SRV_BNDCHK_EN
    logic r_err;
    // Sticky bound error, cleared at the next job start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_err <= 1'b0;
        else if (w_start)           r_err <= 1'b0;
        else if (w_b_err | w_x_err) r_err <= 1'b1;
    end
    assign err = r_err;
`else
    logic w_unused_err;
    assign w_unused_err = w_b_err | w_x_err;
    assign err          = 1'b0;
`endif

endmodule

// File: doc/mac_opnd_srv.md
MAC_OPND_SRV -- requirements
Module: mac_opnd_srv

Interface
REQ-001 SHALL have parameters: PL, default 4, multiplier lanes; DW, default 64, data word width; AW, default 13, word address width.
REQ-002 SHALL have ports: clk in 1 clock; reset in 1 async active-high reset; mac_start in 1 MAC job start; mac_done in 1 MAC job done.
REQ-003 SHALL have MAC-side ports: daptr/dbptr/dxptr/dyptr in AW each; dard/dbrd/dxrd/dywr in 1 each; dardat/dbrdat/dxrdat out DW each; dywdat in DW.
REQ-004 SHALL have length and base ports: dblen/dxlen in AW; base_b/base_x/base_y in AW, RAM word offsets.
REQ-005 SHALL have B RAM ports: rb_cs out 1; rb_we out 1; rb_addr out AW; rb_wdata out DW; rb_rdata in DW, 1-cycle read latency. X and Y RAMs SHALL have identical port sets prefixed rx_ and ry_.
REQ-006 SHALL have host ports: h_req in 1; h_we in 1; h_sel in 2 (0=A, 1=B, 2=X, 3=Y); h_addr in AW; h_wdata in DW; h_ack out 1; h_rdata out DW; err out 1, sticky bound error.

Function
REQ-007 Owner FSM SHALL have states IDLE, HOST, MAC: IDLE->MAC on mac_start; IDLE->HOST on h_req; HOST->IDLE after ack; MAC->IDLE on mac_done.
REQ-008 mac_start SHALL take priority over h_req in the same cycle; h_req SHALL stall (h_ack=0) in MAC.
REQ-009 A operand SHALL be held in a PL x DW register file; dard SHALL return regfile[daptr] on dardat one cycle later; daptr>=PL SHALL return 0.
REQ-010 dbrd SHALL drive rb_cs=1, rb_we=0, rb_addr=base_b+dbptr (mod 2^AW) in the same cycle; dbrdat SHALL equal rb_rdata in the following cycle.
REQ-011 dxrd SHALL map to the X RAM using base_x in the same way as REQ-010.
REQ-012 dywr SHALL drive ry_cs=1, ry_we=1, ry_addr=base_y+dyptr, ry_wdata=dywdat in the same cycle.
REQ-013 dardat, dbrdat and dxrdat SHALL hold their last value in every cycle not directly following the matching read strobe.
REQ-014 base_b/base_x/base_y SHALL be sampled on mac_start and held until the next mac_start.
REQ-015 Host access SHALL take exactly one HOST cycle. A write SHALL set h_ack one cycle after h_req. A read SHALL set h_ack two cycles after h_req, with h_rdata valid in that cycle.
REQ-016 Host addresses SHALL be raw RAM or regfile indices, with no base offset applied.
REQ-017 MAC-side strobes arriving outside MAC SHALL be ignored: no RAM cs, no data change.

Reset
REQ-018 On reset, FSM SHALL go to IDLE; h_ack, err, every RAM cs/we and all data outputs SHALL go to 0; the A regfile and base registers SHALL clear to 0.
REQ-019 Reset asserted mid-job SHALL abort the job immediately; a pending host request SHALL be dropped with no ack.

Configuration
REQ-020 With MAC_OPND_SRV_BNDCHK_EN defined, a B read with dbptr>=dblen or an X read with dxptr>=dxlen SHALL suppress cs, return 0 and set err. err SHALL clear on mac_start.
REQ-021 Without MAC_OPND_SRV_BNDCHK_EN, no check SHALL be made and err SHALL be tied to 0.

Structure
REQ-022 Package mac_pkg SHALL hold the owner state enum, the h_sel encoding, and the PL/DW/AW defaults.
REQ-023 The per-operand read path (cs/addr generation, 1-cycle capture, hold) SHALL be one sub-module, mac_opnd_rdport, instantiated for B and X.

Verification
REQ-024 Host writes A[0..3]=1,2,3,4, then dard with daptr=2 -> dardat=3 on the next cycle and held afterwards.
REQ-025 base_b=0x100, mac_start, dbrd with dbptr=5 -> same-cycle rb_addr=0x105, rb_cs=1; next cycle dbrdat=rb_rdata.
REQ-026 h_req raised in the same cycle as mac_start -> FSM enters MAC; h_ack stays 0 until mac_done; then a write acks after 1 cycle, a read after 2.
REQ-027 With BNDCHK_EN, dblen=64, dbptr=64 -> rb_cs=0, dbrdat=0, err=1; next mac_start -> err=0.
REQ-028 Reset pulse asserted 3 cycles into MAC -> all outputs 0, FSM IDLE, a subsequent dywr is ignored (ry_cs=0).
